video_raster_gen: RTL

Source-side raster generator for arcade cores. It produces the pixel-enable-qualified counters a core uses to fetch pixels. It re-aligns the returned pixel data with HBlank/VBlank/HSync/VSync, and emits the clean stream that the rotation/scaler path consumes. It sits between the core's video fetch logic and the arcade video output stage, and is the transmitting end of that blank/sync/pixel interface.

---
 rtl/video_timing_pkg.sv | 36 +++
 rtl/ce_delay_line.sv | 32 +++
 rtl/video_raster_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing defaults, the counter-width helper and the flag bundle
// carried alongside each fetched pixel through the raster pipeline.
package video_timing_pkg;

  // Default 288x224 active raster inside a 384x264 total frame.
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_H_ACTIVE = 288;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 56;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_V_FP     = 16;
  localparam int DEF_V_SYNC   = 8;
  localparam int DEF_V_BP     = 16;
  localparam int DEF_PIPE     = 2;

  // Flags decoded from the fetch counters, delayed to meet the returned pixel.
  typedef struct packed {
    logic act;   // inside the active area
    logic hb;    // horizontal blank
    logic vb;    // vertical blank
    logic hs;    // horizontal sync
    logic vs;    // vertical sync
    logic sof;   // pixel (0,0)
  } raster_flags_t;

  // What the delay line and output stage hold while nothing valid is in flight.
  localparam raster_flags_t FLAGS_BLANK = '{act: 1'b0, hb: 1'b1, vb: 1'b1,
                                            hs: 1'b0, vs: 1'b0, sof: 1'b0};

  // Bits needed to count 0..total-1, never less than one.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/ce_delay_line.sv
// Pixel-enable qualified shift register with asynchronous clear to a
// parameterised idle value; keeps the flag bundle in step with pixel fetch.
module ce_delay_line #(
  parameter int             W            = 1,
  parameter int             DEPTH_STAGES = 1,
  parameter logic [W-1:0]   RESET_VAL    = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH_STAGES];

  // Shift one stage per enabled clock; reset flushes every stage.
  // NOTE: every stage is cleared on reset (not just the head) so nothing stale
  // can drain out after release; non-blocking assignments let each stage pick
  // up its neighbour's old value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH_STAGES; i++) stage[i] <= RESET_VAL;
    end else if (ce) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH_STAGES-1];

endmodule

// File: rtl/video_raster_gen.sv
// Source-side raster generator: fetch counters for the core, timing flags
// decoded from them, and an output stage that re-aligns returned pixels with
// blank/sync so downstream sees one clean, consistently delayed stream.
module video_raster_gen
  import video_timing_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE     = DEF_PIPE,
  localparam int HT      = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT      = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_width(HT),
  localparam int VW      = cnt_width(VT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  output logic [HW-1:0]    hcnt,
  output logic [VW-1:0]    vcnt,
  input  logic [DEPTH-1:0] rgb_in,
  output logic [DEPTH-1:0] video_out,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START_C = HW'(HS_START);
  localparam logic [HW-1:0] HS_END_C   = HW'(HS_END);
  localparam logic [VW-1:0] VS_START_C = VW'(VS_START);
  localparam logic [VW-1:0] VS_END_C   = VW'(VS_END);

  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $error("video_raster_gen: PIPE must be within 1..4");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_bad_porch
    $error("video_raster_gen: porch and sync widths must be at least 1");
  end
  if (HT > 4096 || VT > 4096) begin : g_bad_total
    $error("video_raster_gen: HT and VT must not exceed 4096");
  end

  raster_flags_t flags_raw;
  raster_flags_t flags_d;
  logic          vs_hold;
  logic          vs_raw;

  // Fetch position: column wraps every line, line wraps every frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Vsync level only changes at the hsync leading column, so both sync edges
  // always land on the same pixel.
  // NOTE: default assignment first so every path assigns vs_raw and no latch
  // is inferred.
  always_comb begin
    vs_raw = vs_hold;
    if (hcnt == HS_START_C) vs_raw = (vcnt >= VS_START_C) && (vcnt < VS_END_C);
  end

  // Hold the vsync level between hsync leading columns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vs_hold <= 1'b0;
    else if (ce)   vs_hold <= vs_raw;
  end

  // Decode the raw timing flags for the column/line currently being fetched.
  always_comb begin
    flags_raw     = FLAGS_BLANK;
    flags_raw.hb  = (hcnt >= H_ACT_C);
    flags_raw.vb  = (vcnt >= V_ACT_C);
    flags_raw.act = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    flags_raw.hs  = (hcnt >= HS_START_C) && (hcnt < HS_END_C);
    flags_raw.vs  = vs_raw;
    flags_raw.sof = (hcnt == '0) && (vcnt == '0);
  end

  ce_delay_line #(
    .W            ($bits(raster_flags_t)),
    .DEPTH_STAGES (PIPE),
    .RESET_VAL    (FLAGS_BLANK)
  ) u_flag_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .d       (flags_raw),
    .q       (flags_d)
  );

  // Output stage: pixel gated to the active area, flags registered with it,
  // frame_start lasting a single clock whatever ce does next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video_out   <= '0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (ce) begin
        video_out   <= flags_d.act ? rgb_in : '0;
        hblank      <= flags_d.hb;
        vblank      <= flags_d.vb;
        hsync       <= flags_d.hs;
        vsync       <= flags_d.vs;
        frame_start <= flags_d.sof;
      end
    end
  end

  assign de = ~(hblank | vblank);

endmodule
